// File: rtl/adder_share_arbiter_pkg.sv
// Shared types and constants for the shared add/subtract arbiter.
// Optional fixed-priority requester 0 is enabled by ADDER_SHARE_ARBITER_PRIO0_EN.
package adder_share_arbiter_pkg;

  localparam int WIDTH_DEF   = 32;
  localparam int TAG_W_DEF   = 4;
  localparam int NUM_REQ_DEF = 3;
  localparam int ID_W_DEF    = 2;

  localparam int REQ_ALU = 0;
  localparam int REQ_BR  = 1;
  localparam int REQ_AGU = 2;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  typedef struct packed {
    logic [ID_W_DEF-1:0]  id;
    logic [TAG_W_DEF-1:0] tag;
    logic [WIDTH_DEF-1:0] sum;
    logic                 cout;
    logic                 ovf;
  } rsp_t;

  // A single requester still needs a one-bit id field.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_share_arbiter_rr_picker.sv
// Round-robin grant picker: combinational one-hot/index grant, pointer advances on accept.
// ADDER_SHARE_ARBITER_PRIO0_EN gives requester 0 absolute priority without moving the pointer.
module adder_share_arbiter_rr_picker #(
  parameter int NUM_REQ = 3,
  parameter int ID_W    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic               accept,
  output logic [ID_W-1:0]    gnt_idx,
  output logic [NUM_REQ-1:0] gnt_onehot
);

  logic [ID_W-1:0]    rr_ptr_r;
  logic [NUM_REQ-1:0] rr_vec_s;
  logic               prio_hit_s;
  logic               rr_found_s;
  logic [ID_W-1:0]    rr_idx_s;

  // First set bit of vec searching upward from ptr+1, wrapping; returns {found, idx}.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] vec,
                                            input logic [ID_W-1:0] ptr);
    logic            found;
    logic [ID_W-1:0] idx;
    logic [ID_W-1:0] cand_idx;
    int              cand;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand     = int'(ptr) + k;
      cand     = (cand >= NUM_REQ) ? cand - NUM_REQ : cand;
      cand_idx = ID_W'(cand);
      if (!found && vec[cand_idx]) begin
        found = 1'b1;
        idx   = cand_idx;
      end else begin
        found = found;
      end
    end
    return {found, idx};
  endfunction

  // Grant selection.
  always_comb begin
    rr_vec_s = req_valid;
`ifdef ADDER_SHARE_ARBITER_PRIO0_EN
    rr_vec_s[0] = 1'b0;
    prio_hit_s  = req_valid[0];
`else
    prio_hit_s  = 1'b0;
`endif
    {rr_found_s, rr_idx_s} = rr_pick(rr_vec_s, rr_ptr_r);
    gnt_idx    = prio_hit_s ? '0 : rr_idx_s;
    gnt_onehot = '0;
    gnt_onehot[gnt_idx] = prio_hit_s | rr_found_s;
  end

  // Pointer starts at the last requester so requester 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_r <= ID_W'(NUM_REQ - 1);
    end else if (accept && !prio_hit_s) begin
      rr_ptr_r <= rr_idx_s;
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// Shares one prefix add/subtract datapath among NUM_REQ requesters through a 2-stage pipeline.
// Build option: ADDER_SHARE_ARBITER_PRIO0_EN (requester 0 fixed priority).
module adder_share_arbiter
  import adder_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int WIDTH   = WIDTH_DEF,
  parameter int TAG_W   = TAG_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]     req_a,
  input  logic [NUM_REQ*WIDTH-1:0]     req_b,
  input  logic [NUM_REQ-1:0]           req_sub,
  input  logic [NUM_REQ*TAG_W-1:0]     req_tag,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [id_width(NUM_REQ)-1:0] rsp_id,
  output logic [TAG_W-1:0]             rsp_tag,
  output logic [WIDTH-1:0]             rsp_sum,
  output logic                         rsp_cout,
  output logic                         rsp_ovf
);

  localparam int ID_W = id_width(NUM_REQ);

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } s2_t;

  logic [WIDTH-1:0]   a_arr_s   [NUM_REQ];
  logic [WIDTH-1:0]   b_arr_s   [NUM_REQ];
  logic [TAG_W-1:0]   tag_arr_s [NUM_REQ];
  logic [ID_W-1:0]    gnt_idx_s;
  logic [NUM_REQ-1:0] gnt_onehot_s;
  logic               s1_en_s, s2_en_s, accept_s;
  logic [WIDTH:0]     add_res_s;

  logic               s1_valid_r, s2_valid_r;
  logic [WIDTH-1:0]   s1_a_r, s1_b_r;
  logic               s1_cin_r;
  logic [ID_W-1:0]    s1_id_r;
  logic [TAG_W-1:0]   s1_tag_r;
  s2_t                s2_r;

  // Kogge-Stone prefix adder; cin is folded into bit 0's generate. Returns {cout, sum}.
  function automatic logic [WIDTH:0] prefix_add(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic             cin);
    logic [WIDTH-1:0] p0, g, p, c;
    p0   = a ^ b;
    g    = a & b;
    p    = p0;
    g[0] = g[0] | (p0[0] & cin);
    for (int d = 1; d < WIDTH; d = d * 2) begin
      for (int i = WIDTH - 1; i >= d; i--) begin
        g[i] = g[i] | (p[i] & g[i-d]);
        p[i] = p[i] & p[i-d];
      end
    end
    c = {g[WIDTH-2:0], cin};
    return {g[WIDTH-1], p0 ^ c};
  endfunction

  // Split the flat request buses into per-requester lanes.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      a_arr_s[i]   = req_a[i*WIDTH +: WIDTH];
      b_arr_s[i]   = req_b[i*WIDTH +: WIDTH];
      tag_arr_s[i] = req_tag[i*TAG_W +: TAG_W];
    end
  end

  assign s2_en_s   = !s2_valid_r || rsp_ready;
  assign s1_en_s   = !s1_valid_r || s2_en_s;
  assign accept_s  = s1_en_s && (|req_valid) && !rst;
  assign req_ready = accept_s ? gnt_onehot_s : '0;

  adder_share_arbiter_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .accept     (accept_s),
    .gnt_idx    (gnt_idx_s),
    .gnt_onehot (gnt_onehot_s)
  );

  // Stage 1: operand register; subtraction is stored as inverted B with carry-in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_a_r     <= '0;
      s1_b_r     <= '0;
      s1_cin_r   <= 1'b0;
      s1_id_r    <= '0;
      s1_tag_r   <= '0;
    end else if (accept_s) begin
      s1_valid_r <= 1'b1;
      s1_a_r     <= a_arr_s[gnt_idx_s];
      s1_b_r     <= req_sub[gnt_idx_s] ? ~b_arr_s[gnt_idx_s] : b_arr_s[gnt_idx_s];
      s1_cin_r   <= req_sub[gnt_idx_s];
      s1_id_r    <= gnt_idx_s;
      s1_tag_r   <= tag_arr_s[gnt_idx_s];
    end else if (s1_en_s) begin
      s1_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= s1_valid_r;
    end
  end

  assign add_res_s = prefix_add(s1_a_r, s1_b_r, s1_cin_r);

  // Stage 2: result register; holds while the consumer stalls a valid result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_r <= 1'b0;
      s2_r       <= '0;
    end else if (s2_en_s) begin
      s2_valid_r <= s1_valid_r;
      s2_r.id    <= s1_id_r;
      s2_r.tag   <= s1_tag_r;
      s2_r.sum   <= add_res_s[WIDTH-1:0];
      s2_r.cout  <= add_res_s[WIDTH];
      s2_r.ovf   <= (s1_a_r[WIDTH-1] == s1_b_r[WIDTH-1]) &&
                    (add_res_s[WIDTH-1] != s1_a_r[WIDTH-1]);
    end else begin
      s2_valid_r <= s2_valid_r;
    end
  end

  assign rsp_valid = s2_valid_r;
  assign rsp_id    = s2_r.id;
  assign rsp_tag   = s2_r.tag;
  assign rsp_sum   = s2_r.sum;
  assign rsp_cout  = s2_r.cout;
  assign rsp_ovf   = s2_r.ovf;

endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Shares one 32-bit parallel-prefix add/subtract datapath between NUM_REQ requesters, for example ALU, branch-target and AGU.
- Round-robin arbitration with a valid/ready request channel per requester.
- Two-stage registered pipeline: operand register, then result register.
- One response channel carries the requester id and tag.
- Sits between the execute-stage issue logic and the shared adder.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- WIDTH, 32, operand and result width.
- TAG_W, 4, opaque tag width returned with each result.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  request valid, one bit per requester.
- req_ready  out  NUM_REQ  request accepted this cycle (at most one bit high).
- req_a  in  NUM_REQ*WIDTH  operand A; slice i belongs to requester i.
- req_b  in  NUM_REQ*WIDTH  operand B.
- req_sub  in  NUM_REQ  1 = A-B, 0 = A+B.
- req_tag  in  NUM_REQ*TAG_W  tag, echoed in the response.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  clog2(NUM_REQ)  index of the requester that owns the result.
- rsp_tag  out  TAG_W  echoed tag.
- rsp_sum  out  WIDTH  A+B, or A+~B+1.
- rsp_cout  out  1  carry out of the MSB.
- rsp_ovf  out  1  signed overflow.

Behaviour:
- Reset (async, rst=1): s1_valid=0, s2_valid=0, rsp_valid=0, rsp_sum/rsp_tag/rsp_id/rsp_cout/rsp_ovf=0, req_ready=0, rr_ptr=NUM_REQ-1 so requester 0 wins first.
- Pipeline enables:
  - s2_en = !s2_valid | rsp_ready
  - s1_en = !s1_valid | s2_en
  - accept = s1_en & |req_valid
- Grant: combinational from req_valid and rr_ptr. The search starts at rr_ptr+1 and wraps modulo NUM_REQ. req_ready[g] = accept for the granted index g; all other bits are 0. req_valid must not depend on req_ready.
- Stage 1, on accept: capture A, B (B inverted when sub), cin=sub, id and tag; set s1_valid=1; rr_ptr<=g. rr_ptr changes only on accept.
- Stage 1 with s1_en and no accept: s1_valid<=0.
- Stage 2, on s2_en: load sum, cout and ovf from the stage-1 operands; s2_valid<=s1_valid.
  - ovf = (A[MSB]==B'[MSB]) & (sum[MSB]!=A[MSB]), where B' is the post-inversion operand.
- Latency: result appears on rsp_* two edges after the accepting edge. Throughput is one result per cycle when rsp_ready=1.
- Occupancy states are EMPTY, ONE and FULL. In FULL with rsp_ready=0, req_ready is all zero.
- Output stability: while rsp_valid & !rsp_ready, every rsp_* output holds stable.
- Simultaneous events: the response handshake and a new accept in the same cycle are legal with no bubble. Requests are never dropped or reordered; results leave in grant order.
- Width: NUM_REQ=1 degenerates to a pass-through pipeline with rsp_id=0.
- Reset mid-operation flushes both stages; in-flight results are lost.

Optional Feature:
- Macro: ADDER_SHARE_ARBITER_PRIO0_EN.
- Defined: requester 0 has fixed absolute priority. It wins whenever req_valid[0]=1 and does not move rr_ptr. The remaining requesters round-robin among themselves.
- Undefined: pure round-robin over all requesters.

Decomposition:
- Shared package holds:
  - WIDTH_DEF=32 and TAG_W_DEF.
  - Requester index constants: REQ_ALU=0, REQ_BR=1, REQ_AGU=2.
  - The rsp struct typedef {id, tag, sum, cout, ovf}.
- One sub-module: rr_picker (NUM_REQ), containing the req vector, pointer and the one-hot/index grant logic.
- The adder is the team's existing 32-bit prefix adder, instantiated in stage 2.

Test Plan:
- Add: req0 a=5, b=7, sub=0, tag=3, rsp_ready=1 -> two edges after accept: rsp_valid=1, sum=12, id=0, tag=3, cout=0, ovf=0.
- Subtract:
  - a=0, b=1, sub=1 -> sum=0xFFFFFFFF, cout=0, ovf=0.
  - a=0x80000000, b=1, sub=1 -> sum=0x7FFFFFFF, cout=1, ovf=1.
  - a=0x7FFFFFFF, b=1, add -> sum=0x80000000, ovf=1.
- Fairness: all three req_valid held high, rsp_ready=1 -> grants in order 0,1,2,0,1,2, one per cycle; rsp_id sequence matches.
- Backpressure: rsp_ready=0 for 6 cycles with req0 streaming tags 1..4 -> exactly 2 accepts, then req_ready=0 and rsp_* stable. On release, tags emerge 1,2,3,4 with no loss or duplication.
- Reset mid-operation: rst pulsed asynchronously with both stages full -> rsp_valid=0 immediately. After release with all requesters valid, the first grant goes to req0.
- Macro: req0 and req1 continuously valid -> with the macro defined, only req0 is granted; with it undefined, grants alternate 0,1,0,1.
